pipeline_hazard_ctrl: RTL and testbench

- Parametrised hazard and pipeline-control unit for the 5-stage core (IF/ID/EX/MEM/WB).
- Keeps its own shadow pipeline of per-stage control metadata (valid, rd, rs1/rs2, regwrite, memread) in lock-step with the datapath latches.
- From that state it drives stall enables, flush/bubble controls and EX-stage forwarding selects.
- Adds three behaviours the current single-issue top lacks: multi-cycle memory stall, a selectable forwarding-or-stall mode, and saturating performance counters.

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 28 ++
 rtl/pipeline_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_pkg : shared stage metadata, forwarding selects and match helper    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package pipe_pkg;

  // Register indices are carried at this width; narrower cores zero-extend.
  localparam int REG_IDX_MAX_W = 8;

  typedef logic [REG_IDX_MAX_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic     regwrite;
    logic     memread;
  } stage_meta_t;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam stage_meta_t c_stage_bubble = '0;

  // x0 is hard-wired zero, so it is never a real producer.
  function automatic logic writes_reg(input stage_meta_t e, input reg_idx_t r);
    return e.valid && e.regwrite && (e.rd != '0) && (e.rd == r);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sat_counter : W-bit event counter that sticks at all-ones                |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] r_value;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_value <= '0;
    end else if (inc && (r_value != {W{1'b1}})) begin
      r_value <= r_value + W'(1);
    end
  end

  assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_hazard_ctrl : 5-stage stall/flush/forwarding control with a     |
// |                        shadow metadata pipe and saturating counters      |
// | Revision             : 1.0                                               |
// +--------------------------------------------------------------------------+
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter bit FWD_EN     = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  pipe_en,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  stage_meta_t r_ex_q;
  stage_meta_t r_mem_q;
  stage_meta_t r_wb_q;
  stage_meta_t w_id_meta;

  reg_idx_t w_rs1;
  reg_idx_t w_rs2;
  logic     w_ex_hits;
  logic     w_mem_hits;
  logic     w_load_use;
  logic     w_raw_nofwd;
  logic     w_hazard;

  assign w_rs1 = reg_idx_t'(id_rs1);
  assign w_rs2 = reg_idx_t'(id_rs2);

  assign w_id_meta = '{valid:    id_valid,
                       rd:       reg_idx_t'(id_rd),
                       rs1:      w_rs1,
                       rs2:      w_rs2,
                       regwrite: id_regwrite,
                       memread:  id_memread};

  assign w_ex_hits  = (id_use_rs1 && writes_reg(r_ex_q, w_rs1)) ||
                      (id_use_rs2 && writes_reg(r_ex_q, w_rs2));
  assign w_mem_hits = (id_use_rs1 && writes_reg(r_mem_q, w_rs1)) ||
                      (id_use_rs2 && writes_reg(r_mem_q, w_rs2));

  assign w_load_use  = w_ex_hits && r_ex_q.memread;
  // Write-first regfile means a WB-stage producer is already visible in ID.
  assign w_raw_nofwd = (FWD_EN == 1'b0) && (w_ex_hits || w_mem_hits);
  assign w_hazard    = id_valid && (w_load_use || w_raw_nofwd);

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    pipe_en      = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (mem_busy) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      pipe_en  = 1'b0;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (w_hazard) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  generate
    if (FWD_EN) begin : g_fwd
      assign fwd_a = writes_reg(r_mem_q, r_ex_q.rs1) ? FWD_EXMEM :
                     writes_reg(r_wb_q,  r_ex_q.rs1) ? FWD_MEMWB : FWD_REG;
      assign fwd_b = writes_reg(r_mem_q, r_ex_q.rs2) ? FWD_EXMEM :
                     writes_reg(r_wb_q,  r_ex_q.rs2) ? FWD_MEMWB : FWD_REG;
    end else begin : g_nofwd
      assign fwd_a = FWD_REG;
      assign fwd_b = FWD_REG;
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ex_q  <= c_stage_bubble;
      r_mem_q <= c_stage_bubble;
      r_wb_q  <= c_stage_bubble;
    end else if (pipe_en) begin
      r_wb_q  <= r_mem_q;
      r_mem_q <= r_ex_q;
      r_ex_q  <= id_ex_bubble ? c_stage_bubble : w_id_meta;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (!mem_busy && !ex_branch_taken && w_hazard),
    .value (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (!mem_busy && ex_branch_taken),
    .value (flush_cnt)
  );

  // Source fields of the later stages only matter while the entry sits in EX.
  logic w_unused;
  assign w_unused = ^{r_mem_q.rs1, r_mem_q.rs2, r_mem_q.memread,
                      r_wb_q.rs1, r_wb_q.rs2, r_wb_q.memread};

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl : directed table, corner sequences and random    |
// |                           stimulus against an in-bench reference model   |
// | Revision                : 1.0                                            |
// +--------------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread;
  logic       ex_branch_taken, mem_busy;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic       pc_en[NI], if_id_en[NI], if_id_flush[NI], id_ex_bubble[NI], pipe_en[NI];
  logic [1:0] fwd_a[NI], fwd_b[NI];
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [1:0]  sc2, fc2;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b1), .CNT_W(16)) dut_fwd (
    .clock(clk), .reset(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_en(pc_en[0]), .if_id_en(if_id_en[0]), .if_id_flush(if_id_flush[0]),
    .id_ex_bubble(id_ex_bubble[0]), .pipe_en(pipe_en[0]),
    .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]), .stall_cnt(sc0), .flush_cnt(fc0));

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b0), .CNT_W(16)) dut_nofwd (
    .clock(clk), .reset(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_en(pc_en[1]), .if_id_en(if_id_en[1]), .if_id_flush(if_id_flush[1]),
    .id_ex_bubble(id_ex_bubble[1]), .pipe_en(pipe_en[1]),
    .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]), .stall_cnt(sc1), .flush_cnt(fc1));

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b1), .CNT_W(2)) dut_sat (
    .clock(clk), .reset(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_en(pc_en[2]), .if_id_en(if_id_en[2]), .if_id_flush(if_id_flush[2]),
    .id_ex_bubble(id_ex_bubble[2]), .pipe_en(pipe_en[2]),
    .fwd_a(fwd_a[2]), .fwd_b(fwd_b[2]), .stall_cnt(sc2), .flush_cnt(fc2));

  typedef struct {
    bit valid; int rs1; int rs2; bit u1; bit u2; int rd; bit rw; bit mr; bit br; bit busy;
  } in_t;
  typedef struct { bit vld; int rd; int rs1; int rs2; bit rw; bit mr; } ent_t;
  typedef struct { bit pc; bit ifid; bit flush; bit bub; bit pe; int fa; int fb; } out_t;
  typedef struct { in_t i; bit pc; bit fl; bit bub; int fa; int fb; int sc; int fc; } vec_t;

  // Model: in-flight instructions by age, 0 = in EX, 1 = in MEM, 2 = in WB.
  ent_t m_st[NI][3];
  int   m_sc[NI], m_fc[NI];
  bit   m_fwd[NI] = '{1'b1, 1'b0, 1'b1};
  int   m_max[NI] = '{65535, 65535, 3};
  out_t last_o[NI];
  bit   last_hz[NI];
  in_t  last_in;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(bit valid, int rs1, int rs2, bit u1, bit u2, int rd,
                             bit rw, bit mr, bit br, bit busy);
    in_t v;
    v.valid = valid; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.rd = rd; v.rw = rw; v.mr = mr; v.br = br; v.busy = busy;
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int s = 0; s < 3; s++) m_st[i][s] = '{vld:0, rd:0, rs1:0, rs2:0, rw:0, mr:0};
      m_sc[i] = 0;
      m_fc[i] = 0;
    end
  endfunction

  // Age of the youngest in-flight producer of r, searching from age 'first'.
  function automatic int producer(int i, int first, int r);
    if (r == 0) return -1;
    for (int s = first; s < 3; s++)
      if (m_st[i][s].vld && m_st[i][s].rw && m_st[i][s].rd == r) return s;
    return -1;
  endfunction

  function automatic int fwd_sel(int i, int r);
    int p;
    p = producer(i, 1, r);
    if (p == 1) return 2;
    if (p == 2) return 1;
    return 0;
  endfunction

  function automatic void predict(int i, in_t v, output out_t o, output bit hz);
    bit lu = 0;
    bit raw = 0;
    int p;
    int srcs[2];
    bit used[2];
    srcs[0] = v.rs1; srcs[1] = v.rs2; used[0] = v.u1; used[1] = v.u2;
    for (int k = 0; k < 2; k++) begin
      if (used[k]) begin
        p = producer(i, 0, srcs[k]);
        if (p == 0 && m_st[i][0].mr) lu = 1;
        if (!m_fwd[i] && (p == 0 || p == 1)) raw = 1;
      end
    end
    hz = v.valid && (lu || raw);
    o = '{pc:1, ifid:1, flush:0, bub:0, pe:1, fa:0, fb:0};
    if (v.busy) begin
      o.pc = 0; o.ifid = 0; o.pe = 0;
    end else if (v.br) begin
      o.flush = 1; o.bub = 1;
    end else if (hz) begin
      o.pc = 0; o.ifid = 0; o.bub = 1;
    end
    if (m_fwd[i]) begin
      o.fa = fwd_sel(i, m_st[i][0].rs1);
      o.fb = fwd_sel(i, m_st[i][0].rs2);
    end
  endfunction

  function automatic void model_update(int i, in_t v, out_t o, bit hz);
    if (v.busy) return;
    m_st[i][2] = m_st[i][1];
    m_st[i][1] = m_st[i][0];
    if (o.bub) m_st[i][0] = '{vld:0, rd:0, rs1:0, rs2:0, rw:0, mr:0};
    else m_st[i][0] = '{vld:v.valid, rd:v.rd, rs1:v.rs1, rs2:v.rs2, rw:v.rw, mr:v.mr};
    if (!v.br && hz && m_sc[i] < m_max[i]) m_sc[i]++;
    if (v.br && m_fc[i] < m_max[i]) m_fc[i]++;
  endfunction

  function automatic logic [31:0] dut_sc(int i);
    case (i)
      0: return 32'(sc0);
      1: return 32'(sc1);
      default: return 32'(sc2);
    endcase
  endfunction

  function automatic logic [31:0] dut_fc(int i);
    case (i)
      0: return 32'(fc0);
      1: return 32'(fc1);
      default: return 32'(fc2);
    endcase
  endfunction

  task automatic xchk(input int i, input bit pc, input bit ifid, input bit fl, input bit bub,
                      input bit pe, input int fa, input int fb, input int sc, input int fc);
    chk($sformatf("u%0d.pc_en", i),        32'(pc_en[i]),        32'(pc));
    chk($sformatf("u%0d.if_id_en", i),     32'(if_id_en[i]),     32'(ifid));
    chk($sformatf("u%0d.if_id_flush", i),  32'(if_id_flush[i]),  32'(fl));
    chk($sformatf("u%0d.id_ex_bubble", i), 32'(id_ex_bubble[i]), 32'(bub));
    chk($sformatf("u%0d.pipe_en", i),      32'(pipe_en[i]),      32'(pe));
    chk($sformatf("u%0d.fwd_a", i),        32'(fwd_a[i]),        fa);
    chk($sformatf("u%0d.fwd_b", i),        32'(fwd_b[i]),        fb);
    chk($sformatf("u%0d.stall_cnt", i),    dut_sc(i),            sc);
    chk($sformatf("u%0d.flush_cnt", i),    dut_fc(i),            fc);
  endtask

  task automatic drive(input in_t v);
    id_valid = v.valid; id_rs1 = 5'(v.rs1); id_rs2 = 5'(v.rs2);
    id_use_rs1 = v.u1; id_use_rs2 = v.u2; id_rd = 5'(v.rd);
    id_regwrite = v.rw; id_memread = v.mr; ex_branch_taken = v.br; mem_busy = v.busy;
  endtask

  // Called at posedge+1; drives, samples mid-cycle and checks every instance vs the model.
  task automatic apply(input in_t v);
    drive(v);
    last_in = v;
    #4;
    for (int i = 0; i < NI; i++) begin
      predict(i, v, last_o[i], last_hz[i]);
      xchk(i, last_o[i].pc, last_o[i].ifid, last_o[i].flush, last_o[i].bub, last_o[i].pe,
           last_o[i].fa, last_o[i].fb, m_sc[i], m_fc[i]);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_update(i, last_in, last_o[i], last_hz[i]);
    #1;
  endtask

  task automatic step(input in_t v);
    apply(v);
    advance();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t tbl[13];
  in_t  nop, lw5, add6, add3, sub4, lw7, add8;

  initial begin
    nop  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lw5  = mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
    add6 = mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    add3 = mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    sub4 = mk(1, 3, 3, 1, 1, 4, 1, 0, 0, 0);
    lw7  = mk(1, 2, 0, 1, 0, 7, 1, 1, 0, 0);
    add8 = mk(1, 7, 7, 1, 1, 8, 1, 0, 0, 0);

    // Expectations for the forwarding instance (u0); fields: in, pc, flush, bubble, fa, fb, stall, flush_cnt.
    tbl[0]  = '{i:lw5,  pc:1, fl:0, bub:0, fa:0, fb:0, sc:0, fc:0};
    tbl[1]  = '{i:add6, pc:0, fl:0, bub:1, fa:0, fb:0, sc:0, fc:0};
    tbl[2]  = '{i:add6, pc:1, fl:0, bub:0, fa:0, fb:0, sc:1, fc:0};
    tbl[3]  = '{i:nop,  pc:1, fl:0, bub:0, fa:1, fb:0, sc:1, fc:0};
    tbl[4]  = '{i:add3, pc:1, fl:0, bub:0, fa:0, fb:0, sc:1, fc:0};
    tbl[5]  = '{i:sub4, pc:1, fl:0, bub:0, fa:0, fb:0, sc:1, fc:0};
    tbl[6]  = '{i:nop,  pc:1, fl:0, bub:0, fa:2, fb:2, sc:1, fc:0};
    tbl[7]  = '{i:lw7,  pc:1, fl:0, bub:0, fa:0, fb:0, sc:1, fc:0};
    tbl[8]  = '{i:mk(1, 7, 7, 1, 1, 8, 1, 0, 1, 0), pc:1, fl:1, bub:1, fa:0, fb:0, sc:1, fc:0};
    tbl[9]  = '{i:nop,  pc:1, fl:0, bub:0, fa:0, fb:0, sc:1, fc:1};
    tbl[10] = '{i:mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0), pc:1, fl:0, bub:0, fa:0, fb:0, sc:1, fc:1};
    tbl[11] = '{i:mk(1, 0, 0, 1, 1, 9, 1, 0, 0, 0), pc:1, fl:0, bub:0, fa:0, fb:0, sc:1, fc:1};
    tbl[12] = '{i:nop,  pc:1, fl:0, bub:0, fa:0, fb:0, sc:1, fc:1};

    rst_n = 1'b0;
    drive(nop);
    #2;
    for (int i = 0; i < NI; i++) xchk(i, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Load-use, back-to-back ALU, branch over a load-use, x0 destination.
    for (int k = 0; k < 13; k++) begin
      apply(tbl[k].i);
      xchk(0, tbl[k].pc, tbl[k].pc, tbl[k].fl, tbl[k].bub, 1,
           tbl[k].fa, tbl[k].fb, tbl[k].sc, tbl[k].fc);
      advance();
    end

    // Memory stall held across a pending load-use stall.
    do_reset();
    step(lw5);
    for (int k = 0; k < 3; k++) begin
      apply(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 1));
      xchk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      advance();
    end
    apply(add6); xchk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0); advance();
    apply(add6); xchk(0, 1, 1, 0, 0, 1, 0, 0, 1, 0); advance();

    // No-forwarding instance: dependent ALU pair stalls twice.
    do_reset();
    apply(add3); xchk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0); advance();
    apply(sub4); xchk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0); advance();
    apply(sub4); xchk(1, 0, 0, 0, 1, 1, 0, 0, 1, 0); advance();
    apply(sub4); xchk(1, 1, 1, 0, 0, 1, 0, 0, 2, 0); advance();
    apply(nop);  xchk(1, 1, 1, 0, 0, 1, 0, 0, 2, 0); advance();

    // Asynchronous reset in the middle of a load-use stall.
    do_reset();
    step(lw5);
    step(add6);
    step(add6);
    step(lw7);
    apply(add8);
    xchk(0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    #1 rst_n = 1'b0;
    #1;
    xchk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(add8); xchk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0); advance();

    // Random traffic on a small register set to provoke frequent dependences.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(mk($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                $urandom_range(0, 9) == 0, $urandom_range(0, 19) < 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
